// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing engine: state encoding, 640x480@60 defaults
// and helpers for the axis totals and counter widths.
package vga_timing_pkg;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // A total of 1 or 2 still needs a one-bit counter.
    function automatic int cnt_width(input int total);
        return (total > 2) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Free-running modulo-TOTAL counter for one display axis.
// The wrap pulse marks the enabled cycle on which the count returns to zero.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = 8,
    parameter int W     = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_r;

    assign cnt  = cnt_r;
    assign wrap = en && (cnt_r == LAST);

    // Count register: cleared by reset or while the engine is idle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r <= {W{1'b0}};
        end else if (wrap) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster timing generator that pulls pixels from a show-ahead FIFO and drives
// registered colour, sync, blanking and coordinate outputs one cycle behind the counters.
module vga_timing_engine
    import vga_timing_pkg::*;
#(
    parameter int                 H_ACTIVE  = DEF_H_ACTIVE,
    parameter int                 H_FP      = DEF_H_FP,
    parameter int                 H_SYNC    = DEF_H_SYNC,
    parameter int                 H_BP      = DEF_H_BP,
    parameter int                 V_ACTIVE  = DEF_V_ACTIVE,
    parameter int                 V_FP      = DEF_V_FP,
    parameter int                 V_SYNC    = DEF_V_SYNC,
    parameter int                 V_BP      = DEF_V_BP,
    parameter logic               HSYNC_POL = 1'b0,
    parameter logic               VSYNC_POL = 1'b0,
    parameter int                 PIX_W     = 8,
    parameter logic [3*PIX_W-1:0] UF_COLOR  = {(3*PIX_W){1'b0}},
    parameter logic               SOG       = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [3*PIX_W-1:0] fifo_data,
    output logic               fifo_rreq,
    output logic [PIX_W-1:0]   red,
    output logic [PIX_W-1:0]   green,
    output logic [PIX_W-1:0]   blue,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n,
    output logic               sync_n,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic               frame_start,
    output logic               underflow
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    vga_state_e         state_r;
    vga_state_e         state_next_s;
    logic               run_s;
    logic               active_s;
    logic               hs_on_s;
    logic               vs_on_s;
    logic               rreq_s;
    logic [HW-1:0]      h_cnt_s;
    logic [VW-1:0]      v_cnt_s;
    logic               h_wrap_s;
    logic               v_wrap_unused;

    logic [3*PIX_W-1:0] rgb_next_s;
    logic               hs_next_s;
    logic               vs_next_s;
    logic               bn_next_s;
    logic               sn_next_s;
    logic [11:0]        x_next_s;
    logic [11:0]        y_next_s;
    logic               fs_next_s;
    logic               uf_next_s;

    logic [3*PIX_W-1:0] rgb_r;
    logic               hs_r;
    logic               vs_r;
    logic               bn_r;
    logic               sn_r;
    logic [11:0]        x_r;
    logic [11:0]        y_r;
    logic               fs_r;
    logic               uf_r;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(HW)) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (!run_s),
        .en    (run_s),
        .cnt   (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(VW)) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (!run_s),
        .en    (h_wrap_s),
        .cnt   (v_cnt_s),
        .wrap  (v_wrap_unused)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_DATA;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state plus raster decode; the first non-empty cycle in WAIT_DATA already runs at (0,0).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT_DATA: begin
                if (!fifo_empty) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = WAIT_DATA;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = WAIT_DATA;
        endcase
        run_s    = (state_r == RUN) || !fifo_empty;
        active_s = run_s && (h_cnt_s < H_ACT_END) && (v_cnt_s < V_ACT_END);
        hs_on_s  = (h_cnt_s >= H_SYNC_BEG) && (h_cnt_s < H_SYNC_END);
        vs_on_s  = (v_cnt_s >= V_SYNC_BEG) && (v_cnt_s < V_SYNC_END);
        rreq_s   = active_s && !fifo_empty && !rst;
    end

    assign fifo_rreq = rreq_s;

    // Output values for the pixel currently addressed by the counters.
    always_comb begin
        rgb_next_s = {(3*PIX_W){1'b0}};
        hs_next_s  = ~HSYNC_POL;
        vs_next_s  = ~VSYNC_POL;
        bn_next_s  = 1'b0;
        sn_next_s  = 1'b1;
        x_next_s   = 12'd0;
        y_next_s   = 12'd0;
        fs_next_s  = 1'b0;
        uf_next_s  = 1'b0;
        if (run_s) begin
            bn_next_s = active_s;
            if (active_s && !fifo_empty) begin
                rgb_next_s = fifo_data;
            end else if (active_s) begin
                rgb_next_s = UF_COLOR;
                uf_next_s  = 1'b1;
            end else begin
                rgb_next_s = {(3*PIX_W){1'b0}};
            end
            hs_next_s = hs_on_s ? HSYNC_POL : ~HSYNC_POL;
            vs_next_s = vs_on_s ? VSYNC_POL : ~VSYNC_POL;
            sn_next_s = SOG ? ~(hs_on_s || vs_on_s) : 1'b1;
            x_next_s  = 12'(h_cnt_s);
            y_next_s  = 12'(v_cnt_s);
            fs_next_s = (h_cnt_s == {HW{1'b0}}) && (v_cnt_s == {VW{1'b0}});
        end else begin
            rgb_next_s = {(3*PIX_W){1'b0}};
            uf_next_s  = 1'b0;
        end
    end

    // Single output pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= {(3*PIX_W){1'b0}};
            hs_r  <= ~HSYNC_POL;
            vs_r  <= ~VSYNC_POL;
            bn_r  <= 1'b0;
            sn_r  <= 1'b1;
            x_r   <= 12'd0;
            y_r   <= 12'd0;
            fs_r  <= 1'b0;
            uf_r  <= 1'b0;
        end else begin
            rgb_r <= rgb_next_s;
            hs_r  <= hs_next_s;
            vs_r  <= vs_next_s;
            bn_r  <= bn_next_s;
            sn_r  <= sn_next_s;
            x_r   <= x_next_s;
            y_r   <= y_next_s;
            fs_r  <= fs_next_s;
            uf_r  <= uf_next_s;
        end
    end

    assign red         = rgb_r[3*PIX_W-1:2*PIX_W];
    assign green       = rgb_r[2*PIX_W-1:PIX_W];
    assign blue        = rgb_r[PIX_W-1:0];
    assign hsync       = hs_r;
    assign vsync       = vs_r;
    assign blank_n     = bn_r;
    assign sync_n      = sn_r;
    assign x           = x_r;
    assign y           = y_r;
    assign frame_start = fs_r;
    assign underflow   = uf_r;

endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 are front porch, sync and back porch widths in pixels; each SHALL be at least 1.
REQ-002 V_ACTIVE, 480, visible lines per frame; V_FP 10, V_SYNC 2, V_BP 33 are the vertical equivalents in lines; each SHALL be at least 1.
REQ-003 HSYNC_POL, 0, asserted level of hsync; VSYNC_POL, 0, asserted level of vsync.
REQ-004 PIX_W, 8, bits per colour channel; UF_COLOR, 0, 3*PIX_W-bit {r,g,b} value driven on underflow.
REQ-005 SOG, 0, when 1 sync_n carries composite sync; when 0 sync_n is held at 1.
REQ-006 clk  in  1  pixel clock; one clock only; all logic on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 fifo_empty  in  1  show-ahead FIFO is empty; fifo_data is valid whenever this is low.
REQ-009 fifo_data  in  3*PIX_W  pixel {r,g,b}; the word is consumed on any cycle with fifo_rreq=1.
REQ-010 fifo_rreq  out  1  FIFO read strobe.
REQ-011 red, green, blue  out  PIX_W each  registered colour outputs.
REQ-012 hsync, vsync, blank_n, sync_n  out  1 each  registered timing outputs.
REQ-013 x, y  out  12 each  registered coordinate of the pixel currently on the colour outputs.
REQ-014 frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).
REQ-015 underflow  out  1  one-cycle pulse aligned with an output pixel that had no FIFO data.

Function
REQ-016 The block SHALL use two states: WAIT_DATA and RUN.
REQ-017 WAIT_DATA -> RUN occurs on the first cycle with fifo_empty=0; h_cnt=0 and v_cnt=0 on the first RUN cycle.
REQ-018 RUN has no exit except rst; an underflow SHALL NOT resynchronise the timing.
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), wrap to 0, and increment v_cnt on wrap.
REQ-020 v_cnt SHALL count 0..V_TOTAL-1 and wrap to 0 when h_cnt wraps at V_TOTAL-1.
REQ-021 Counter width SHALL be the clog2 of the total; x and y are zero-extended to 12 bits.
REQ-022 Active region: RUN, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-023 fifo_rreq = active AND NOT fifo_empty, combinational from counter state; it SHALL be 0 outside the active region and in WAIT_DATA.
REQ-024 H sync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; V sync for the same rule on v_cnt, held for whole lines.
REQ-025 All outputs SHALL appear exactly 1 cycle after their counter state (a single pipeline stage); colour SHALL be fifo_data sampled with its rreq.
REQ-026 Active pixel with fifo_empty=1: colour SHALL be UF_COLOR and underflow=1 in the same output cycle; no read is issued.
REQ-027 Colour SHALL be 0 and blank_n SHALL be 0 outside the active region.
REQ-028 sync_n = NOT(hsync asserted OR vsync asserted) when SOG=1.
REQ-029 frame_start SHALL be 1 only for output pixel h=0, v=0.

Reset
REQ-030 On rst, state=WAIT_DATA, counters=0, and all outputs take their reset values by the next edge.
REQ-031 Output reset values: colour 0, blank_n 0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, sync_n 1, x=y=0, frame_start 0, underflow 0.
REQ-032 The same reset values SHALL be held throughout WAIT_DATA.
REQ-033 rst mid-frame SHALL abort the frame; fifo_rreq SHALL be 0 in the rst cycle.

Structure
REQ-034 Package vga_timing_pkg SHALL hold the state enum, the 640x480@60 default constants, and a total/width helper function.
REQ-035 One sub-module, vga_axis_counter (parametrised total, enable in, wrap out), SHALL be instantiated twice, once for H and once for V.

Verification (use H=4/1/2/1, V=3/1/1/1 unless noted: H_TOTAL=8, V_TOTAL=6)
REQ-036 Start: fifo_empty held 1 for 5 cycles then 0 -> first rreq on the cycle fifo_empty falls; frame_start and the first pixel appear 1 cycle later.
REQ-037 Full frame with FIFO always ready -> exactly 12 rreq per 48 cycles; hsync low for h=5..6; vsync low on line 4 only; blank_n=1 for 12 pixels.
REQ-038 fifo_empty forced 1 on output pixel (2,1) -> colour=UF_COLOR, underflow one pulse, no rreq that cycle; (3,1) resumes with the next FIFO word.
REQ-039 rst asserted at (2,2) -> next cycle every output holds its reset value; fifo_rreq=0; restart waits for fifo_empty=0.
REQ-040 HSYNC_POL=1, VSYNC_POL=1, SOG=1 -> syncs are active-high; sync_n low exactly when either sync is asserted.
REQ-041 Default 640x480 parameters -> 800x525 period; frame_start every 420000 cycles; x wraps from 799 to 0.
